// File: rtl/obuft_pkg.sv
`timescale 1ps/1ps
// obuft_pkg: shared types and constants for the bus turnaround output bank.
package obuft_pkg;

  // Width of the turnaround/hold down-counter (supports 0..15 cycles).
  localparam int CNT_W = 4;

  // Bus ownership phases.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TURN_ON  = 3'd1,
    DRIVE    = 3'd2,
    HOLD     = 3'd3,
    TURN_OFF = 3'd4
  } state_e;

  // True when the parameter set is usable: at least one bit, counts fit the counter.
  function automatic bit params_ok(input int width, input int turn, input int hold);
    return (width >= 32'sd1) &&
           (turn >= 32'sd0) && (turn <= 32'sd15) &&
           (hold >= 32'sd0) && (hold <= 32'sd15);
  endfunction

endpackage

// File: rtl/obuft_pad_bank.sv
`timescale 1ps/1ps
// obuft_pad_bank: one bufif0 per bit; t=1 floats the pad, t=0 drives dout.
`celldefine
module obuft_pad_bank #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] dout,
  input  logic             t,
  output wire  [WIDTH-1:0] pad
);

  genvar k;
  for (k = 0; k < WIDTH; k++) begin : g_pad
    bufif0 u_buf (pad[k], dout[k], t);
  end

endmodule
`endcelldefine

// File: rtl/obuft_bus_turnaround.sv
`timescale 1ps/1ps
// obuft_bus_turnaround: registered tri-state output bank for a shared bus.
// REQ/GNT handshake with hi-Z dead cycles before driving and after release,
// plus hold cycles that keep the last word on the bus after REQ drops.
module obuft_bus_turnaround
  import obuft_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               TURN_CYCLES = 1,
  parameter int               HOLD_CYCLES = 1,
  parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             REQ,
  output logic             GNT,
  output logic             T,
  output wire  [WIDTH-1:0] O
);

  if (!params_ok(WIDTH, TURN_CYCLES, HOLD_CYCLES)) begin : g_param_err
    $error("obuft_bus_turnaround: need WIDTH>=1 and TURN_CYCLES/HOLD_CYCLES in 0..15");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TURN_LOAD =
    (TURN_CYCLES > 32'sd0) ? CNT_W'(TURN_CYCLES - 32'sd1) : CNT_ZERO;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 32'sd0) ? CNT_W'(HOLD_CYCLES - 32'sd1) : CNT_ZERO;
  localparam bit TURN_NONE = (TURN_CYCLES == 32'sd0);
  localparam bit HOLD_NONE = (HOLD_CYCLES == 32'sd0);
  // Where the bus goes once the hold window is over; with no dead cycles the
  // release lands straight in IDLE (TURN_LOAD is then zero as IDLE expects).
  localparam state_e AFTER_HOLD = TURN_NONE ? IDLE : TURN_OFF;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             capture_s;
  logic             t_r;
  logic             t_nxt_s;
  logic             gnt_r;
  logic             gnt_nxt_s;
  logic [WIDTH-1:0] dout_r;

  // Next-state, counter reload/decrement and data-capture decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (REQ) begin
          if (TURN_NONE) begin
            state_nxt_s = DRIVE;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = TURN_ON;
            cnt_nxt_s   = TURN_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TURN_ON: begin
        // A dropped request abandons the acquisition before the bus is ever driven.
        if (!REQ) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = DRIVE;
          capture_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      DRIVE: begin
        if (REQ) begin
          capture_s = 1'b1;
        end else if (!HOLD_NONE) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = HOLD_LOAD;
        end else begin
          state_nxt_s = AFTER_HOLD;
          cnt_nxt_s   = TURN_LOAD;
        end
      end
      HOLD: begin
        // Re-request while still driving: resume without any turnaround.
        if (REQ) begin
          state_nxt_s = DRIVE;
          capture_s   = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = AFTER_HOLD;
          cnt_nxt_s   = TURN_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      TURN_OFF: begin
        // REQ is deliberately ignored until the other driver has had its dead time.
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Pad control decoded from the next state so T/GNT are plain flop outputs.
  always_comb begin
    t_nxt_s   = 1'b1;
    gnt_nxt_s = 1'b0;
    case (state_nxt_s)
      DRIVE: begin
        t_nxt_s   = 1'b0;
        gnt_nxt_s = 1'b1;
      end
      HOLD: begin
        t_nxt_s   = 1'b0;
        gnt_nxt_s = 1'b0;
      end
      default: begin
        t_nxt_s   = 1'b1;
        gnt_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter, pad control and output data registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      t_r     <= 1'b1;
      gnt_r   <= 1'b0;
      dout_r  <= INIT;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      t_r     <= t_nxt_s;
      gnt_r   <= gnt_nxt_s;
      if (capture_s) begin
        dout_r <= I;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign T   = t_r;
  assign GNT = gnt_r;

  obuft_pad_bank #(
    .WIDTH(WIDTH)
  ) u_pads (
    .dout(dout_r),
    .t   (t_r),
    .pad (O)
  );

endmodule

// File: tb/tb_obuft_bus_turnaround.sv
`timescale 1ps/1ps
// tb_obuft_bus_turnaround: four parameter variants driven by one REQ/I stream,
// each compared against a timeline-based reference model.
module tb_obuft_bus_turnaround;

  localparam int N  = 160;
  localparam int NI = 4;

  int          turn_p  [NI] = '{2, 1, 0, 2};
  int          hold_p  [NI] = '{1, 3, 0, 1};
  int          width_p [NI] = '{8, 8, 8, 16};
  logic [15:0] init_p  [NI] = '{16'h0000, 16'h0081, 16'h0000, 16'h1234};

  logic        CLK;
  logic        RST;
  logic        REQ;
  logic [15:0] I;
  logic        t0, t1, t2, t3;
  logic        g0, g1, g2, g3;
  wire  [7:0]  o0, o1, o2;
  wire  [15:0] o3;

  bit          req_a [N];
  logic [15:0] din_a [N];
  bit          exp_t [NI][N];
  bit          exp_g [NI][N];
  logic [15:0] exp_d [NI][N];
  logic        obs_t [NI][N];
  logic        obs_g [NI][N];
  logic [15:0] obs_o [NI][N];
  logic [15:0] obs_dout [NI];

  int checks;
  int errors;

  obuft_bus_turnaround #(.WIDTH(8), .TURN_CYCLES(2), .HOLD_CYCLES(1), .INIT(8'h00)) u0 (
    .CLK(CLK), .RST(RST), .I(I[7:0]), .REQ(REQ), .GNT(g0), .T(t0), .O(o0));
  obuft_bus_turnaround #(.WIDTH(8), .TURN_CYCLES(1), .HOLD_CYCLES(3), .INIT(8'h81)) u1 (
    .CLK(CLK), .RST(RST), .I(I[7:0]), .REQ(REQ), .GNT(g1), .T(t1), .O(o1));
  obuft_bus_turnaround #(.WIDTH(8), .TURN_CYCLES(0), .HOLD_CYCLES(0), .INIT(8'h00)) u2 (
    .CLK(CLK), .RST(RST), .I(I[7:0]), .REQ(REQ), .GNT(g2), .T(t2), .O(o2));
  obuft_bus_turnaround #(.WIDTH(16), .TURN_CYCLES(2), .HOLD_CYCLES(1), .INIT(16'h1234)) u3 (
    .CLK(CLK), .RST(RST), .I(I), .REQ(REQ), .GNT(g3), .T(t3), .O(o3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hi-Z pad pattern as seen through the 16-bit observation slot.
  function automatic logic [15:0] hz_o(input int ii);
    logic [15:0] zz;
    zz = 16'hzzzz;
    return (width_p[ii] == 16) ? zz : {8'h00, zz[7:0]};
  endfunction

  function automatic logic [15:0] exp_o(input int ii, input int k);
    if (exp_t[ii][k]) return hz_o(ii);
    return (width_p[ii] == 16) ? exp_d[ii][k] : {8'h00, exp_d[ii][k][7:0]};
  endfunction

  // Reference: walk the REQ timeline in ownership episodes. Defaults are hi-Z;
  // an episode starting at edge k drives from k+TURN (if REQ stays up), each
  // release is followed by up to HOLD frozen cycles, then TURN+1 hi-Z edges
  // (dead time plus the mandatory idle edge) before a new request is seen.
  task automatic build_model(input int ii, input int n);
    int tc, hc, k, j, m, h, x;
    bit aborted, regrab, leave;
    logic [15:0] last;
    tc = turn_p[ii];
    hc = hold_p[ii];
    last = 16'h0000;
    for (int q = 0; q < n; q++) begin
      exp_t[ii][q] = 1'b1;
      exp_g[ii][q] = 1'b0;
      exp_d[ii][q] = 16'h0000;
    end
    k = 0;
    while (k < n) begin
      if (!req_a[k]) begin
        k++;
        continue;
      end
      aborted = 1'b0;
      j = k + 1;
      while (j <= k + tc && j < n && !aborted) begin
        if (!req_a[j]) aborted = 1'b1;
        else j++;
      end
      if (aborted) begin
        k = j + 1;
        continue;
      end
      if (k + tc >= n) begin
        k = n;
        continue;
      end
      m = k + tc;
      leave = 1'b0;
      while (m < n && !leave) begin
        if (req_a[m]) begin
          last = din_a[m];
          exp_t[ii][m] = 1'b0;
          exp_g[ii][m] = 1'b1;
          exp_d[ii][m] = last;
          m++;
        end else begin
          regrab = 1'b0;
          x = m;
          h = m;
          if (hc > 0) begin
            exp_t[ii][m] = 1'b0;
            exp_d[ii][m] = last;
            h = m + 1;
            while (h <= m + hc && h < n && !regrab) begin
              if (req_a[h]) begin
                regrab = 1'b1;
              end else begin
                if (h < m + hc) begin
                  exp_t[ii][h] = 1'b0;
                  exp_d[ii][h] = last;
                end
                h++;
              end
            end
            x = m + hc;
          end
          if (regrab) begin
            m = h;
          end else begin
            leave = 1'b1;
            k = x + tc + 1;
          end
        end
      end
      if (!leave) k = n;
    end
  endtask

  task automatic sample(input int k);
    obs_t[0][k] = t0; obs_g[0][k] = g0; obs_o[0][k] = {8'h00, o0};
    obs_t[1][k] = t1; obs_g[1][k] = g1; obs_o[1][k] = {8'h00, o1};
    obs_t[2][k] = t2; obs_g[2][k] = g2; obs_o[2][k] = {8'h00, o2};
    obs_t[3][k] = t3; obs_g[3][k] = g3; obs_o[3][k] = o3;
    obs_dout[0] = {8'h00, u0.dout_r};
    obs_dout[1] = {8'h00, u1.dout_r};
    obs_dout[2] = {8'h00, u2.dout_r};
    obs_dout[3] = u3.dout_r;
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n; k++) begin
      REQ = req_a[k];
      I   = din_a[k];
      @(posedge CLK);
      #1;
      sample(k);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = 1'b0;
    I   = 16'h0000;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic clear_stim(input int n);
    for (int k = 0; k < n; k++) begin
      req_a[k] = 1'b0;
      din_a[k] = 16'h0000;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 1'b1;
    I   = 16'hA5A5;
    repeat (2) @(posedge CLK);
    #1;
    sample(0);
    for (int ii = 0; ii < NI; ii++) begin
      checks++;
      if (obs_t[ii][0] !== 1'b1 || obs_g[ii][0] !== 1'b0 || obs_o[ii][0] !== hz_o(ii) ||
          obs_dout[ii] !== init_p[ii]) begin
        errors++;
        $display("FAIL reset inst%0d: T=%b GNT=%b O=%h dout=%h, expected T=1 GNT=0 O=%h dout=%h",
                 ii, obs_t[ii][0], obs_g[ii][0], obs_o[ii][0], obs_dout[ii], hz_o(ii), init_p[ii]);
      end
    end
    REQ = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    n = 16;
    clear_stim(n);
    for (int k = 0; k < n; k++) begin
      req_a[k] = (k < 6);
      din_a[k] = 16'h3C3C;
    end
    do_reset();
    play(n);
    for (int ii = 0; ii < NI; ii++) build_model(ii, n);
    for (int ii = 0; ii < NI; ii++) begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_t[ii][k] !== exp_t[ii][k] || obs_g[ii][k] !== exp_g[ii][k] || obs_o[ii][k] !== exp_o(ii, k)) begin
          errors++;
          $display("FAIL basic inst%0d edge%0d: T=%b GNT=%b O=%h, expected T=%b GNT=%b O=%h",
                   ii, k, obs_t[ii][k], obs_g[ii][k], obs_o[ii][k], exp_t[ii][k], exp_g[ii][k], exp_o(ii, k));
        end
      end
    end
    // Hand-derived timeline for TURN=2/HOLD=1: dead edges 0,1; drive 2..5; hold 6; off 7,8; idle 9.
    checks++;
    if (obs_t[0][1] !== 1'b1 || obs_t[0][2] !== 1'b0 || obs_g[0][2] !== 1'b1 || obs_o[0][2] !== 16'h003C) begin
      errors++;
      $display("FAIL basic_first_drive: T1=%b T2=%b GNT2=%b O2=%h, expected 1 0 1 003c",
               obs_t[0][1], obs_t[0][2], obs_g[0][2], obs_o[0][2]);
    end
    checks++;
    if (obs_g[0][6] !== 1'b0 || obs_t[0][6] !== 1'b0 || obs_o[0][6] !== 16'h003C ||
        obs_t[0][7] !== 1'b1 || obs_t[0][9] !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: GNT6=%b T6=%b O6=%h T7=%b T9=%b, expected 0 0 003c 1 1",
               obs_g[0][6], obs_t[0][6], obs_o[0][6], obs_t[0][7], obs_t[0][9]);
    end
  endtask

  task automatic test_regrab();
    int n;
    n = 20;
    clear_stim(n);
    for (int k = 0; k < n; k++) begin
      req_a[k] = (k < 8) || (k >= 9 && k < 16);
      din_a[k] = 16'h5A5A;
    end
    do_reset();
    play(n);
    for (int ii = 0; ii < NI; ii++) build_model(ii, n);
    for (int ii = 0; ii < NI; ii++) begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_t[ii][k] !== exp_t[ii][k] || obs_g[ii][k] !== exp_g[ii][k] || obs_o[ii][k] !== exp_o(ii, k)) begin
          errors++;
          $display("FAIL regrab inst%0d edge%0d: T=%b GNT=%b O=%h, expected T=%b GNT=%b O=%h",
                   ii, k, obs_t[ii][k], obs_g[ii][k], obs_o[ii][k], exp_t[ii][k], exp_g[ii][k], exp_o(ii, k));
        end
      end
    end
    // HOLD=3 instance: bus stays driven across the one-cycle REQ gap.
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (obs_t[1][k] !== 1'b0 || obs_o[1][k] !== 16'h005A) begin
        errors++;
        $display("FAIL regrab_no_gap edge%0d: T=%b O=%h, expected T=0 O=005a", k, obs_t[1][k], obs_o[1][k]);
      end
    end
    checks++;
    if (obs_g[1][8] !== 1'b0 || obs_g[1][9] !== 1'b1) begin
      errors++;
      $display("FAIL regrab_gnt: GNT8=%b GNT9=%b, expected 0 1", obs_g[1][8], obs_g[1][9]);
    end
  endtask

  task automatic test_zero_params();
    int n;
    n = 10;
    clear_stim(n);
    for (int k = 0; k < n; k++) begin
      req_a[k] = (k >= 2 && k < 6);
      din_a[k] = 16'($urandom);
    end
    do_reset();
    play(n);
    for (int ii = 0; ii < NI; ii++) build_model(ii, n);
    for (int ii = 0; ii < NI; ii++) begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_t[ii][k] !== exp_t[ii][k] || obs_g[ii][k] !== exp_g[ii][k] || obs_o[ii][k] !== exp_o(ii, k)) begin
          errors++;
          $display("FAIL zero inst%0d edge%0d: T=%b GNT=%b O=%h, expected T=%b GNT=%b O=%h",
                   ii, k, obs_t[ii][k], obs_g[ii][k], obs_o[ii][k], exp_t[ii][k], exp_g[ii][k], exp_o(ii, k));
        end
      end
    end
    checks++;
    if (obs_t[2][1] !== 1'b1 || obs_t[2][2] !== 1'b0 || obs_o[2][2] !== {8'h00, din_a[2][7:0]} ||
        obs_t[2][6] !== 1'b1 || obs_g[2][6] !== 1'b0) begin
      errors++;
      $display("FAIL zero_latency: T1=%b T2=%b O2=%h T6=%b GNT6=%b, expected 1 0 %h 1 0",
               obs_t[2][1], obs_t[2][2], obs_o[2][2], obs_t[2][6], obs_g[2][6], {8'h00, din_a[2][7:0]});
    end
  endtask

  task automatic test_abort_ignore();
    int n;
    n = 24;
    clear_stim(n);
    for (int k = 0; k < n; k++) begin
      req_a[k] = (k == 0) || (k >= 4 && k < 10) || (k >= 12);
      din_a[k] = 16'($urandom);
    end
    do_reset();
    play(n);
    for (int ii = 0; ii < NI; ii++) build_model(ii, n);
    for (int ii = 0; ii < NI; ii++) begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_t[ii][k] !== exp_t[ii][k] || obs_g[ii][k] !== exp_g[ii][k] || obs_o[ii][k] !== exp_o(ii, k)) begin
          errors++;
          $display("FAIL abort inst%0d edge%0d: T=%b GNT=%b O=%h, expected T=%b GNT=%b O=%h",
                   ii, k, obs_t[ii][k], obs_g[ii][k], obs_o[ii][k], exp_t[ii][k], exp_g[ii][k], exp_o(ii, k));
        end
      end
    end
    // TURN=2/HOLD=1: abort keeps edges 0..3 hi-Z; release at 10, off 11..12,
    // single idle edge 13, fresh dead time 14..15, driving again at 16.
    checks++;
    if (obs_t[0][0] !== 1'b1 || obs_t[0][1] !== 1'b1 || obs_t[0][2] !== 1'b1 || obs_t[0][3] !== 1'b1) begin
      errors++;
      $display("FAIL abort_never_driven: T0..3=%b%b%b%b, expected 1111",
               obs_t[0][0], obs_t[0][1], obs_t[0][2], obs_t[0][3]);
    end
    checks++;
    if (obs_t[0][13] !== 1'b1 || obs_t[0][14] !== 1'b1 || obs_t[0][15] !== 1'b1 ||
        obs_t[0][16] !== 1'b0 || obs_g[0][16] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_turn_off: T13..16=%b%b%b%b GNT16=%b, expected 1110 1",
               obs_t[0][13], obs_t[0][14], obs_t[0][15], obs_t[0][16], obs_g[0][16]);
    end
  endtask

  task automatic test_reset_mid_drive();
    int n;
    n = 8;
    clear_stim(n);
    for (int k = 0; k < n; k++) begin
      req_a[k] = 1'b1;
      din_a[k] = 16'hBEEF;
    end
    do_reset();
    play(n);
    for (int ii = 0; ii < NI; ii++) build_model(ii, n);
    for (int ii = 0; ii < NI; ii++) begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_t[ii][k] !== exp_t[ii][k] || obs_g[ii][k] !== exp_g[ii][k] || obs_o[ii][k] !== exp_o(ii, k)) begin
          errors++;
          $display("FAIL midrst_pre inst%0d edge%0d: T=%b GNT=%b O=%h, expected T=%b GNT=%b O=%h",
                   ii, k, obs_t[ii][k], obs_g[ii][k], obs_o[ii][k], exp_t[ii][k], exp_g[ii][k], exp_o(ii, k));
        end
      end
    end
    REQ = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    sample(0);
    for (int ii = 0; ii < NI; ii++) begin
      checks++;
      if (obs_t[ii][0] !== 1'b1 || obs_g[ii][0] !== 1'b0 || obs_o[ii][0] !== hz_o(ii) ||
          obs_dout[ii] !== init_p[ii]) begin
        errors++;
        $display("FAIL midrst inst%0d: T=%b GNT=%b O=%h dout=%h, expected T=1 GNT=0 O=%h dout=%h",
                 ii, obs_t[ii][0], obs_g[ii][0], obs_o[ii][0], obs_dout[ii], hz_o(ii), init_p[ii]);
      end
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    sample(1);
    // Out of reset with REQ high: a fresh acquisition (hi-Z), never a hold.
    checks++;
    if (obs_t[3][1] !== 1'b1 || obs_g[3][1] !== 1'b0 || obs_t[2][1] !== 1'b0 ||
        obs_o[2][1] !== 16'h00EF) begin
      errors++;
      $display("FAIL midrst_after: T3=%b GNT3=%b T2=%b O2=%h, expected 1 0 0 00ef",
               obs_t[3][1], obs_g[3][1], obs_t[2][1], obs_o[2][1]);
    end
    REQ = 1'b0;
  endtask

  task automatic test_random();
    int p;
    int len;
    bit lvl;
    for (int r = 0; r < 6; r++) begin
      p = 0;
      lvl = 1'b0;
      while (p < N) begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 5));
        for (int q = 0; q < len && p < N; q++) begin
          req_a[p] = lvl;
          din_a[p] = 16'($urandom);
          p++;
        end
        lvl = !lvl;
      end
      do_reset();
      play(N);
      for (int ii = 0; ii < NI; ii++) build_model(ii, N);
      for (int ii = 0; ii < NI; ii++) begin
        for (int k = 0; k < N; k++) begin
          checks++;
          if (obs_t[ii][k] !== exp_t[ii][k] || obs_g[ii][k] !== exp_g[ii][k] || obs_o[ii][k] !== exp_o(ii, k)) begin
            errors++;
            $display("FAIL random r%0d inst%0d edge%0d: T=%b GNT=%b O=%h, expected T=%b GNT=%b O=%h",
                     r, ii, k, obs_t[ii][k], obs_g[ii][k], obs_o[ii][k], exp_t[ii][k], exp_g[ii][k], exp_o(ii, k));
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    REQ = 1'b0;
    I   = 16'h0000;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_regrab();
    test_zero_params();
    test_abort_ignore();
    test_reset_mid_drive();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
